majority_run_tracker: RTL and testbench
=======================================

# majority_run_tracker

Sequential stage directly downstream of the three-input pair/triple (majority) detector. Each enabled cycle it samples the detector's 1-bit result and tracks how many consecutive samples were true, the longest such run, and the total number of true samples. It raises a registered `alarm` once a run reaches a programmable threshold. It is the first stateful consumer of the detector in the datapath and drives the status/LED logic.

## Interface
- `p_nbits`, default 4: width of the run, max and total counters; legal range 2..8.
- `p_thresh`, default 3: run length at which `alarm` asserts; legal range 1..(2^p_nbits − 1).

- `clk` — input, 1 bit: sole clock; all state updates on the rising edge.
- `rst` — input, 1 bit: reset, synchronous, active-high.
- `en` — input, 1 bit: sample strobe; `det` is consumed only in cycles where `en`=1.
- `det` — input, 1 bit: majority result from the pair/triple detector.
- `clear` — input, 1 bit: synchronous clear of all statistics; same effect as `rst`.
- `run` — output, `p_nbits` bits: current consecutive-true run length.
- `max_run` — output, `p_nbits` bits: longest run since the last reset or clear.
- `total` — output, `p_nbits` bits: count of sampled `det`=1, modulo 2^p_nbits.
- `alarm` — output, 1 bit: high while the FSM is in the ALARM state.

## Operation
- FSM states:
  - IDLE: `run`=0.
  - RUN: 0 < `run` < `p_thresh`.
  - ALARM: `run` ≥ `p_thresh`.
- Transitions are evaluated only when `en`=1. With `en`=0, all state and counters hold.
- `en`=1, `det`=1:
  - `run` increments, saturating at 2^p_nbits − 1.
  - Next state is ALARM if the new `run` ≥ `p_thresh`; otherwise RUN.
  - `total` increments and wraps (2^p_nbits − 1 → 0).
- `en`=1, `det`=0: `run` becomes 0 and the state goes to IDLE from any state. `total` is unchanged.
- `max_run` updates to max(`max_run`, next `run`) in the same edge as `run`, so it never lags `run`.
- `p_thresh`=1: the first true sample moves IDLE → ALARM directly; RUN is never entered.
- `alarm` = (state == ALARM). It is decoded from the state register only, never from `det` or `en`.
- Priority, highest first: `rst`, then `clear`, then `en`. When `rst` or `clear` is high, `en`/`det` in that cycle are ignored.
- `det` is treated as a registered-clean input. The block adds no input synchronizer.

## Timing
- Reset values (after `rst` or `clear` edge): state IDLE, `run`=0, `max_run`=0, `total`=0, `alarm`=0.
- All outputs are registered with no combinational path from inputs to outputs.
- Latency: a sample taken at edge N is visible on all outputs immediately after edge N (1-cycle latency from input valid).
- Reset or clear asserted mid-run: takes effect at that edge. The sample presented in that cycle is lost, and sampling resumes the next cycle.
- Saturation: at `run` = 2^p_nbits − 1, further true samples hold `run`, stay in ALARM, and still increment `total`.
- Back-to-back `en` every cycle is supported. There is no back-pressure and no ready signal.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `en`=1, `det`=1 → `run`=0, `max_run`=0, `total`=0, `alarm`=0.
- Threshold (defaults): `en`=1 with `det` = 1,1,1,0 → `run` = 1,2,3,0; `alarm` = 0,0,1,0; `max_run`=3; `total`=3.
- Hold/gap: `det`=1 continuously, `en` = 1,0,1,0,1 → `run` = 1,1,2,2,3; `alarm` goes high only after the 5th edge.
- Saturation and wrap (`p_nbits`=4): 17 consecutive enabled `det`=1 samples → `run`=15, `max_run`=15, `alarm`=1, `total`=1 (wrapped).
- Clear priority: after a run of 2, assert `clear`=1 with `en`=1, `det`=1 → all outputs 0. The next enabled `det`=1 gives `run`=1, `total`=1.
- `p_thresh`=1: the first enabled `det`=1 → `alarm`=1, `run`=1. The next enabled `det`=0 → `alarm`=0, `run`=0, `max_run`=1.

Source files
------------

// File: rtl/majority_run_tracker.sv
// majority_run_tracker
// Consumes the 1-bit majority detector result on enabled cycles and keeps
// the current true-run length, the longest run, a wrapping count of true
// samples, and a registered alarm once the run reaches p_thresh.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | run == 0
// S_RUN   | 0 < run < p_thresh
// S_ALARM | run >= p_thresh (alarm asserted)
module majority_run_tracker #(
    parameter int p_nbits  = 4,
    parameter int p_thresh = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               det,
    input  logic               clear,
    output logic [p_nbits-1:0] run,
    output logic [p_nbits-1:0] max_run,
    output logic [p_nbits-1:0] total,
    output logic               alarm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    localparam logic [p_nbits-1:0] C_SAT    = '1;
    localparam logic [p_nbits-1:0] C_THRESH = p_nbits'(p_thresh);
    localparam logic [p_nbits-1:0] C_ONE    = p_nbits'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [p_nbits-1:0] r_run;
    logic [p_nbits-1:0] r_max;
    logic [p_nbits-1:0] r_total;
    logic [p_nbits-1:0] w_run_nxt;
    logic [p_nbits-1:0] w_max_nxt;
    logic [p_nbits-1:0] w_total_nxt;

    // Next state and counter values; everything holds unless a sample is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_total_nxt = r_total;
        w_max_nxt   = r_max;
        if (en) begin
            if (det) begin
                w_run_nxt   = (r_run == C_SAT) ? r_run : r_run + C_ONE;
                w_total_nxt = r_total + C_ONE;
                w_state_nxt = (w_run_nxt >= C_THRESH) ? S_ALARM : S_RUN;
            end else begin
                w_run_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        end
        // Compare against the next run so max_run moves on the same edge.
        if (w_run_nxt > r_max) begin
            w_max_nxt = w_run_nxt;
        end
    end

    // State and statistics registers; reset and clear both discard the sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_max   <= '0;
            r_total <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_max   <= w_max_nxt;
            r_total <= w_total_nxt;
        end
    end

    assign run     = r_run;
    assign max_run = r_max;
    assign total   = r_total;
    assign alarm   = (r_state == S_ALARM);

endmodule

// File: tb/tb_majority_run_tracker.sv
// Bench for majority_run_tracker: a default instance (thresh 3) and a
// thresh-1 instance share the same stimulus and are checked against a
// plain arithmetic model of run/max/total/alarm.
module tb_majority_run_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       det = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] run_a, max_a, total_a;
    logic       alarm_a;
    logic [3:0] run_b, max_b, total_b;
    logic       alarm_b;

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance: index 0 = thresh 3, index 1 = thresh 1
    int m_run[2];
    int m_max[2];
    int m_total[2];
    int m_thresh[2];

    always #5 clk = ~clk;

    majority_run_tracker #(.p_nbits(4), .p_thresh(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .det(det), .clear(clear),
        .run(run_a), .max_run(max_a), .total(total_a), .alarm(alarm_a)
    );

    majority_run_tracker #(.p_nbits(4), .p_thresh(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .det(det), .clear(clear),
        .run(run_b), .max_run(max_b), .total(total_b), .alarm(alarm_b)
    );

    typedef struct {
        bit rst;
        bit clear;
        bit en;
        bit det;
        int exp_run;
        int exp_max;
        int exp_total;
        int exp_alarm;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit e, input bit d);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                m_run[k] = 0;
                m_max[k] = 0;
                m_total[k] = 0;
            end else if (e) begin
                if (d) begin
                    if (m_run[k] < 15) m_run[k] = m_run[k] + 1;
                    m_total[k] = (m_total[k] + 1) % 16;
                end else begin
                    m_run[k] = 0;
                end
                if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
            end
        end
    endtask

    task automatic model_check();
        chk("a.run",   int'(run_a),   m_run[0]);
        chk("a.max",   int'(max_a),   m_max[0]);
        chk("a.total", int'(total_a), m_total[0]);
        chk("a.alarm", int'(alarm_a), (m_run[0] >= m_thresh[0]) ? 1 : 0);
        chk("b.run",   int'(run_b),   m_run[1]);
        chk("b.max",   int'(max_b),   m_max[1]);
        chk("b.total", int'(total_b), m_total[1]);
        chk("b.alarm", int'(alarm_b), (m_run[1] >= m_thresh[1]) ? 1 : 0);
    endtask

    // Drive one cycle, sample 1 time unit after the edge, compare to model.
    task automatic step(input bit r, input bit c, input bit e, input bit d);
        rst = r;
        clear = c;
        en = e;
        det = d;
        @(posedge clk);
        #1;
        model_update(r, c, e, d);
        model_check();
    endtask

    vec_t vecs[16];

    initial begin
        m_thresh[0] = 3;
        m_thresh[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0;
            m_max[k] = 0;
            m_total[k] = 0;
        end

        //          rst clr en det  run max tot alarm
        vecs[0]  = '{1, 0, 1, 1,  0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 1,  0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 1,  1, 1, 1, 0};
        vecs[3]  = '{0, 0, 1, 1,  2, 2, 2, 0};
        vecs[4]  = '{0, 0, 1, 1,  3, 3, 3, 1};
        vecs[5]  = '{0, 0, 1, 0,  0, 3, 3, 0};
        vecs[6]  = '{0, 0, 1, 1,  1, 3, 4, 0};
        vecs[7]  = '{0, 0, 0, 1,  1, 3, 4, 0};
        vecs[8]  = '{0, 0, 1, 1,  2, 3, 5, 0};
        vecs[9]  = '{0, 0, 0, 1,  2, 3, 5, 0};
        vecs[10] = '{0, 0, 1, 1,  3, 3, 6, 1};
        vecs[11] = '{0, 0, 1, 0,  0, 3, 6, 0};
        vecs[12] = '{0, 0, 1, 1,  1, 3, 7, 0};
        vecs[13] = '{0, 0, 1, 1,  2, 3, 8, 0};
        vecs[14] = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[15] = '{0, 0, 1, 1,  1, 1, 1, 0};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].clear, vecs[i].en, vecs[i].det);
            chk($sformatf("vec%0d.run", i),   int'(run_a),   vecs[i].exp_run);
            chk($sformatf("vec%0d.max", i),   int'(max_a),   vecs[i].exp_max);
            chk($sformatf("vec%0d.total", i), int'(total_a), vecs[i].exp_total);
            chk($sformatf("vec%0d.alarm", i), int'(alarm_a), vecs[i].exp_alarm);
        end

        // saturation and total wrap
        step(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 1);
        chk("sat.run",   int'(run_a),   15);
        chk("sat.max",   int'(max_a),   15);
        chk("sat.alarm", int'(alarm_a), 1);
        chk("sat.total", int'(total_a), 1);

        // threshold of one: straight to alarm, then back to idle
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        chk("t1.alarm_on", int'(alarm_b), 1);
        chk("t1.run_on",   int'(run_b),   1);
        step(0, 0, 1, 0);
        chk("t1.alarm_off", int'(alarm_b), 0);
        chk("t1.run_off",   int'(run_b),   0);
        chk("t1.max",       int'(max_b),   1);

        // randomized traffic biased toward true samples to reach saturation
        for (int i = 0; i < 600; i++) begin
            int r;
            bit rr, cc, ee, dd;
            r  = int'($urandom_range(0, 99));
            rr = (r < 2);
            cc = (r >= 2 && r < 5);
            ee = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 5) != 0);
            step(rr, cc, ee, dd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
